// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC timestamp block.
//   FRAC_PER_SEC_DEF : default number of fraction strobes per second
//   SEC_W_DEF        : default width of the seconds counter
//   FRAC_W_DEF       : default width of the fraction counter
//   state_e          : timestamp FSM state encoding (IDLE / RUN)
// ---------------------------------------------------------------------------
package rtc_pkg;

  localparam int FRAC_PER_SEC_DEF = 16;
  localparam int SEC_W_DEF        = 32;
  localparam int FRAC_W_DEF       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// Two-flop synchronizer followed by a rising-edge detector. The tick is a
// single mclock cycle and appears so that logic clocked on the third rising
// edge after the input rises sees it.
// Ports:
//   mclock   : sampling clock
//   reset    : asynchronous active-low reset
//   async_in : asynchronous level input
//   tick     : one-cycle pulse on each synchronized rising edge
// ---------------------------------------------------------------------------
module edge_sync (
  input  logic mclock,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic vld1_q;
  logic vld2_q;
  logic armed_q;
  logic armed_d;

  // sync_q only carries a genuine post-reset sample once vld2_q is set.
  // The detector arms only after such a sample shows the input low, so a
  // level already high at reset release never produces a tick.
  always_comb begin
    armed_d = armed_q | (vld2_q & ~sync_q);
  end

  always_ff @(posedge mclock or negedge reset) begin
    if (!reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      meta_q  <= async_in;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      vld1_q  <= 1'b1;
      vld2_q  <= vld1_q;
      armed_q <= armed_d;
    end
  end

  assign tick = armed_q & sync_q & ~prev_q;

endmodule

// File: rtl/rtc_timestamp.sv
// ---------------------------------------------------------------------------
// rtc_timestamp
// Seconds / fraction time counter driven by external RTC strobes, with a
// snapshot port that captures the counter value on request.
// Ports:
//   mclock   : sole clock
//   reset    : asynchronous active-low reset
//   sec_in   : asynchronous once-per-second strobe
//   msec_in  : asynchronous fraction strobe (FRAC_PER_SEC per second)
//   sync_in  : asynchronous SYNC level, rising edge zeroes the counters
//   snap_req : mclock-synchronous snapshot request level
//   snap_ack : one-cycle pulse, ts_sec/ts_frac updated this cycle
//   ts_sec   : captured seconds value
//   ts_frac  : captured fraction value
//   running  : high while the FSM is in RUN
//   frac_ovf : sticky, fraction strobe arrived with counter saturated
// FRAC_W must satisfy 2**FRAC_W >= FRAC_PER_SEC.
// ---------------------------------------------------------------------------
module rtc_timestamp
  import rtc_pkg::*;
#(
  parameter int FRAC_PER_SEC = FRAC_PER_SEC_DEF,
  parameter int SEC_W        = SEC_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF
) (
  input  logic              mclock,
  input  logic              reset,
  input  logic              sec_in,
  input  logic              msec_in,
  input  logic              sync_in,
  input  logic              snap_req,
  output logic              snap_ack,
  output logic [SEC_W-1:0]  ts_sec,
  output logic [FRAC_W-1:0] ts_frac,
  output logic              running,
  output logic              frac_ovf
);

  localparam logic [FRAC_W-1:0] FRAC_MAX = FRAC_W'(FRAC_PER_SEC - 1);

  logic sec_tick;
  logic msec_tick;
  logic sync_tick;

  edge_sync u_sec_sync  (.mclock(mclock), .reset(reset), .async_in(sec_in),  .tick(sec_tick));
  edge_sync u_msec_sync (.mclock(mclock), .reset(reset), .async_in(msec_in), .tick(msec_tick));
  edge_sync u_sync_sync (.mclock(mclock), .reset(reset), .async_in(sync_in), .tick(sync_tick));

  state_e              state_q,      state_d;
  logic [SEC_W-1:0]    sec_cnt_q,    sec_cnt_d;
  logic [FRAC_W-1:0]   frac_cnt_q,   frac_cnt_d;
  logic                frac_ovf_q,   frac_ovf_d;
  logic [SEC_W-1:0]    ts_sec_q,     ts_sec_d;
  logic [FRAC_W-1:0]   ts_frac_q,    ts_frac_d;
  logic                snap_ack_q,   snap_ack_d;
  logic                running_q,    running_d;
  logic                snap_prev_q;
  logic                snap_armed_q, snap_armed_d;
  logic                snap_edge;

  // snap_req is already synchronous, so only a one-cycle history is kept.
  // The armed flag requires snap_req to be seen low after reset, so a
  // request held across reset release is not mistaken for a new edge.
  always_comb begin
    snap_armed_d = snap_armed_q | ~snap_req;
    snap_edge    = snap_armed_q & snap_req & ~snap_prev_q;
  end

  // Next-state logic. Only one tick acts per cycle, in the order
  // sync > sec > msec; a lower-priority tick in the same cycle is dropped.
  // The snapshot captures the current (pre-update) register values.
  always_comb begin
    state_d    = state_q;
    sec_cnt_d  = sec_cnt_q;
    frac_cnt_d = frac_cnt_q;
    frac_ovf_d = frac_ovf_q;
    ts_sec_d   = ts_sec_q;
    ts_frac_d  = ts_frac_q;
    snap_ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (sync_tick || sec_tick) begin
          state_d    = RUN;
          sec_cnt_d  = '0;
          frac_cnt_d = '0;
        end
      end
      RUN: begin
        if (sync_tick) begin
          sec_cnt_d  = '0;
          frac_cnt_d = '0;
          frac_ovf_d = 1'b0;
        end else if (sec_tick) begin
          sec_cnt_d  = sec_cnt_q + SEC_W'(1);
          frac_cnt_d = '0;
        end else if (msec_tick) begin
          if (frac_cnt_q == FRAC_MAX) begin
            frac_ovf_d = 1'b1;
          end else begin
            frac_cnt_d = frac_cnt_q + FRAC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (snap_edge) begin
      ts_sec_d   = sec_cnt_q;
      ts_frac_d  = frac_cnt_q;
      snap_ack_d = 1'b1;
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge mclock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sec_cnt_q    <= '0;
      frac_cnt_q   <= '0;
      frac_ovf_q   <= 1'b0;
      ts_sec_q     <= '0;
      ts_frac_q    <= '0;
      snap_ack_q   <= 1'b0;
      running_q    <= 1'b0;
      snap_prev_q  <= 1'b0;
      snap_armed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_cnt_q    <= sec_cnt_d;
      frac_cnt_q   <= frac_cnt_d;
      frac_ovf_q   <= frac_ovf_d;
      ts_sec_q     <= ts_sec_d;
      ts_frac_q    <= ts_frac_d;
      snap_ack_q   <= snap_ack_d;
      running_q    <= running_d;
      snap_prev_q  <= snap_req;
      snap_armed_q <= snap_armed_d;
    end
  end

  assign snap_ack = snap_ack_q;
  assign ts_sec   = ts_sec_q;
  assign ts_frac  = ts_frac_q;
  assign running  = running_q;
  assign frac_ovf = frac_ovf_q;

endmodule

// File: tb/tb_rtc_timestamp.sv
// Testbench for rtc_timestamp: strobes are driven as multi-cycle pulses,
// every snapshot request pushes the expected timestamp into a queue and
// the ack monitor pops and compares it.
module tb_rtc_timestamp;

   logic        mclock;
   logic        reset;
   logic        secIn;
   logic        msecIn;
   logic        syncIn;
   logic        snapReq;
   logic        snapAck;
   logic [31:0] tsSec;
   logic [3:0]  tsFrac;
   logic        running;
   logic        fracOvf;

   int checkCount = 0;
   int errorCount = 0;

   logic [63:0] expQueue[$];

   // Reference model of the time counter, advanced by the stimulus tasks
   logic [31:0] expSec;
   logic [3:0]  expFrac;
   logic        expOvf;
   logic        expRun;

   rtc_timestamp dut (
      .mclock   (mclock),
      .reset    (reset),
      .sec_in   (secIn),
      .msec_in  (msecIn),
      .sync_in  (syncIn),
      .snap_req (snapReq),
      .snap_ack (snapAck),
      .ts_sec   (tsSec),
      .ts_frac  (tsFrac),
      .running  (running),
      .frac_ovf (fracOvf)
   );

   // Free-running 100 MHz clock
   initial begin
      mclock = 1'b0;
      forever #5 mclock = ~mclock;
   end

   // Compare one observed value with its expectation and log any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns after the last one
   task automatic cycles(input int n);
      repeat (n) @(posedge mclock);
      #1;
   endtask

   // Raise the chosen strobes together for 3 cycles, let them fall and
   // fully drain the synchronizers, then update the model and check flags
   task automatic applyStimulus(input logic s, input logic m, input logic y);
      secIn  = s;
      msecIn = m;
      syncIn = y;
      cycles(3);
      secIn  = 1'b0;
      msecIn = 1'b0;
      syncIn = 1'b0;
      cycles(4);
      if (!expRun) begin
         if (y || s) begin
            expRun  = 1'b1;
            expSec  = '0;
            expFrac = '0;
         end
      end else if (y) begin
         expSec  = '0;
         expFrac = '0;
         expOvf  = 1'b0;
      end else if (s) begin
         expSec  = expSec + 32'd1;
         expFrac = '0;
      end else if (m) begin
         if (expFrac == 4'd15) expOvf = 1'b1;
         else expFrac = expFrac + 4'd1;
      end
      checkOutput("running", {63'd0, running}, {63'd0, expRun});
      checkOutput("frac_ovf", {63'd0, fracOvf}, {63'd0, expOvf});
   endtask

   // Single-cycle snapshot request with its expected capture queued
   task automatic snapshot();
      snapReq = 1'b1;
      expQueue.push_back({28'd0, expSec, expFrac});
      cycles(1);
      snapReq = 1'b0;
      cycles(2);
   endtask

   // Every ack must match the oldest outstanding request
   always @(posedge mclock) begin
      logic [63:0] e;
      #1;
      if (snapAck) begin
         if (expQueue.size() == 0) begin
            checkOutput("unexpected_ack", {63'd0, snapAck}, 64'd0);
         end else begin
            e = expQueue.pop_front();
            checkOutput("snap_ts", {28'd0, tsSec, tsFrac}, e);
         end
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_running"}, {63'd0, running}, 64'd0);
      checkOutput({tag, "_ovf"}, {63'd0, fracOvf}, 64'd0);
      checkOutput({tag, "_ack"}, {63'd0, snapAck}, 64'd0);
      checkOutput({tag, "_ts"}, {28'd0, tsSec, tsFrac}, 64'd0);
   endtask

   initial begin
      reset   = 1'b1;
      secIn   = 1'b0;
      msecIn  = 1'b0;
      syncIn  = 1'b0;
      snapReq = 1'b0;
      expSec  = '0;
      expFrac = '0;
      expOvf  = 1'b0;
      expRun  = 1'b0;
      #2 reset = 1'b0;
      cycles(3);
      checkAllZero("reset");

      @(negedge mclock) reset = 1'b1;
      cycles(3);

      // IDLE: snapshot gives 0/0, fraction strobes ignored
      snapshot();
      applyStimulus(1'b0, 1'b1, 1'b0);

      // First second strobe starts RUN on the third edge after the rise
      secIn = 1'b1;
      cycles(2);
      checkOutput("run_lat2", {63'd0, running}, 64'd0);
      cycles(1);
      checkOutput("run_lat3", {63'd0, running}, 64'd1);
      secIn = 1'b0;
      cycles(4);
      expRun = 1'b1;
      snapshot();

      applyStimulus(1'b1, 1'b0, 1'b0);
      snapshot();

      // SYNC zeroes, then five fraction strobes
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      snapshot();

      // Fraction saturation and sticky overflow
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      snapshot();
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      snapshot();
      applyStimulus(1'b1, 1'b0, 1'b0);
      snapshot();

      // Same-cycle priority cases
      applyStimulus(1'b1, 1'b1, 1'b0);
      snapshot();
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      snapshot();
      applyStimulus(1'b1, 1'b0, 1'b1);
      snapshot();

      // Back-to-back requests every two cycles, then one long request
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         snapReq = 1'b1;
         expQueue.push_back({28'd0, expSec, expFrac});
         cycles(1);
         snapReq = 1'b0;
         cycles(1);
      end
      cycles(2);
      snapReq = 1'b1;
      expQueue.push_back({28'd0, expSec, expFrac});
      cycles(6);
      snapReq = 1'b0;
      cycles(2);
      checkOutput("ts_hold", {28'd0, tsSec, tsFrac}, {28'd0, expSec, expFrac});

      // Seconds wrap from all-ones to zero without a flag
      @(negedge mclock);
      force dut.sec_cnt_q = 32'hFFFF_FFFF;
      @(posedge mclock);
      #1;
      release dut.sec_cnt_q;
      expSec = 32'hFFFF_FFFF;
      cycles(1);
      snapshot();
      applyStimulus(1'b1, 1'b0, 1'b0);
      snapshot();

      // Reset during a held request aborts it; outputs return to zero
      snapReq = 1'b1;
      #3 reset = 1'b0;
      cycles(2);
      checkAllZero("mid_reset");
      @(negedge mclock) reset = 1'b1;
      expSec  = '0;
      expFrac = '0;
      expOvf  = 1'b0;
      expRun  = 1'b0;
      cycles(7);
      snapReq = 1'b0;
      cycles(2);
      checkAllZero("post_reset");

      // A strobe already high at release must not start RUN
      secIn = 1'b1;
      reset = 1'b0;
      cycles(2);
      @(negedge mclock) reset = 1'b1;
      cycles(6);
      checkOutput("high_at_release", {63'd0, running}, 64'd0);
      secIn = 1'b0;
      cycles(4);
      applyStimulus(1'b1, 1'b0, 1'b0);
      snapshot();

      cycles(3);
      checkOutput("pending_snaps", 64'(expQueue.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/rtc_timestamp.md
RTC_TIMESTAMP -- requirements
Module: rtc_timestamp

Interface
REQ-001 Parameter: FRAC_PER_SEC, default 16, number of msec strobes per second.
REQ-002 Parameter: SEC_W, default 32, width of the seconds counter.
REQ-003 Parameter: FRAC_W, default 4, width of the fraction counter; SHALL satisfy 2**FRAC_W >= FRAC_PER_SEC.
REQ-004 mclock  in  1  sole clock; all state SHALL be on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low (0 = reset); assertion is asynchronous, release is taken on mclock.
REQ-006 sec_in  in  1  once-per-second strobe from the RTC timebase; high for at least 3 mclock cycles; not mclock-synchronous.
REQ-007 msec_in  in  1  fraction strobe from the RTC timebase, FRAC_PER_SEC per second; same timing properties as sec_in.
REQ-008 sync_in  in  1  external SYNC level; not mclock-synchronous.
REQ-009 snap_req  in  1  snapshot request level; mclock-synchronous.
REQ-010 snap_ack  out  1  one-cycle pulse: ts_sec/ts_frac updated this cycle.
REQ-011 ts_sec  out  SEC_W  captured seconds value.
REQ-012 ts_frac  out  FRAC_W  captured fraction value.
REQ-013 running  out  1  1 when the FSM is in RUN.
REQ-014 frac_ovf  out  1  sticky flag: msec strobe received with fraction counter already at FRAC_PER_SEC-1.

Function
REQ-015 sec_in, msec_in and sync_in SHALL each pass through a 2-flop synchronizer, then a rising-edge detector producing a 1-cycle tick (sec_tick, msec_tick, sync_tick); input rise to tick latency SHALL be 3 mclock cycles.
REQ-016 FSM states: IDLE, RUN. IDLE -> RUN on sec_tick or sync_tick; RUN -> IDLE only via reset.
REQ-017 Entering RUN SHALL zero sec_cnt and frac_cnt in the same cycle.
REQ-018 In IDLE, msec_tick SHALL be ignored; counters hold 0.
REQ-019 In RUN, on sec_tick: sec_cnt <= sec_cnt+1 (modulo 2**SEC_W, 0xFFFFFFFF -> 0 with no flag), frac_cnt <= 0.
REQ-020 In RUN, on msec_tick: frac_cnt <= frac_cnt+1, saturating at FRAC_PER_SEC-1; a tick arriving at saturation SHALL set frac_ovf and leave frac_cnt unchanged.
REQ-021 Priority for same-cycle ticks: sync_tick > sec_tick > msec_tick; the lower-priority tick is discarded (no frac_ovf from a discarded tick).
REQ-022 In RUN, sync_tick SHALL zero sec_cnt and frac_cnt and clear frac_ovf.
REQ-023 A snapshot SHALL be taken on a rising edge of snap_req (previous-cycle value 0, current 1), detected without synchronizer.
REQ-024 Snapshot: ts_sec/ts_frac SHALL take the sec_cnt/frac_cnt register values present in the cycle the edge is detected (pre-update), with snap_ack high in the next cycle for exactly 1 cycle.
REQ-025 Snapshots SHALL be honoured in IDLE (capturing 0/0); running indicates validity.
REQ-026 ts_sec/ts_frac SHALL hold between snapshots; snap_req held high SHALL produce only one snapshot.
REQ-027 Back-to-back snapshot edges (every 2 cycles) SHALL each produce an ack; no request is dropped.

Reset
REQ-028 On reset=0: state IDLE; sec_cnt, frac_cnt, ts_sec, ts_frac = 0; snap_ack, running, frac_ovf = 0; synchronizer and edge-detect flops = 0.
REQ-029 Reset mid-operation SHALL abort any pending snapshot (no ack after release).
REQ-030 An input already high at reset release SHALL NOT produce a tick until it falls and rises again.

Structure
REQ-031 Package rtc_pkg SHALL hold FRAC_PER_SEC, SEC_W and FRAC_W defaults and the FSM state encoding (IDLE=1'b0, RUN=1'b1).
REQ-032 Sub-module edge_sync (2-flop synchronizer + rising-edge detector, async active-low reset) SHALL be instantiated for sec_in, msec_in and sync_in.

Verification
REQ-033 Reset release, sec_in pulse (3 cycles high) -> running=1 at 3rd cycle after rise, counters 0; second sec pulse -> sec_cnt=1.
REQ-034 RUN, 5 msec pulses then snap_req edge -> snap_ack 1 cycle later, ts_sec=0, ts_frac=5.
REQ-035 RUN, 17 msec pulses without sec -> frac_cnt=15, frac_ovf=1 after the 16th; next sec pulse -> frac_cnt=0, frac_ovf stays 1.
REQ-036 sec_in and msec_in rising in the same cycle -> sec_cnt+1, frac_cnt=0, frac_ovf unchanged; sync_in in the same cycle as sec_in -> sec_cnt=0, frac_cnt=0.
REQ-037 Force sec_cnt=0xFFFFFFFF, sec pulse -> sec_cnt=0, no flag; snap_req edge -> ts_sec=0.
REQ-038 snap_req high for 10 cycles with reset pulsed low in cycle 1 -> no snap_ack; all outputs 0 after release.
